// File: rtl/slice_state_writeback.sv
// slice_state_writeback
// Final stage of the slice add/sub chain. Saturates the registered 24-bit sum
// using both overflow flags, writes it into a 2**ADR_W-entry state store, and
// reads the next state_value back for the chain. It also captures log and
// sigma-delta samples on trigger and counts saturated writes.
//
// Ports
//   clock_200               slice clock, rising edge
//   reset                   synchronous active-high reset (overrides slice_enable)
//   slice_enable            clock enable for every state-changing action
//   add_sub_result          registered signed sum from the second add/sub
//   overflow_stage_1        first add/sub overflow, one cycle ahead of its result
//   overflow_stage_2        second add/sub overflow, aligned with add_sub_result
//   state_write_adr         write address, aligned with add_sub_result
//   state_read_adr          read address for the next state_value
//   log_trigger             capture write data into log_value_out
//   sigma_delta_out_trigger capture write data into sigma_delta_out
//   state_value             registered read data (write-first bypass)
//   log_value_out           log sample
//   sigma_delta_out         sigma-delta sample
//   init_busy               high while the store is being cleared
//   sat_event               one-cycle pulse after a saturated write
//   sat_count               saturating count of saturated writes
module slice_state_writeback #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned ADR_W     = 4,
    parameter int unsigned SAT_CNT_W = 16
) (
    input  logic                 clock_200,
    input  logic                 reset,
    input  logic                 slice_enable,
    input  logic [DATA_W-1:0]    add_sub_result,
    input  logic                 overflow_stage_1,
    input  logic                 overflow_stage_2,
    input  logic [ADR_W-1:0]     state_write_adr,
    input  logic [ADR_W-1:0]     state_read_adr,
    input  logic                 log_trigger,
    input  logic                 sigma_delta_out_trigger,
    output logic [DATA_W-1:0]    state_value,
    output logic [DATA_W-1:0]    log_value_out,
    output logic [DATA_W-1:0]    sigma_delta_out,
    output logic                 init_busy,
    output logic                 sat_event,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam int unsigned Depth = 2 ** ADR_W;

    localparam logic [DATA_W-1:0] FullPos = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] FullNeg = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e               state_q, state_d;
    logic [ADR_W-1:0]     clr_ptr_q, clr_ptr_d;
    logic                 ovf1_q;
    logic [DATA_W-1:0]    mem_q [Depth];
    logic [DATA_W-1:0]    state_value_q;
    logic [DATA_W-1:0]    log_value_q;
    logic [DATA_W-1:0]    sigma_delta_q;
    logic                 sat_event_q;
    logic [SAT_CNT_W-1:0] sat_count_q;

    logic                 run_en;
    logic                 sat_active;
    logic [DATA_W-1:0]    wdata;

    // FSM next-state: sweep the clear pointer through the whole store once.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            StClear: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ADR_W'(Depth - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                clr_ptr_d = '0;
            end
            default: begin
                state_d   = StClear;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock_200) begin
        if (reset) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    assign run_en = (state_q == StRun) && slice_enable;

    // Delay the stage-1 flag so it lines up with the sum it belongs to.
    always_ff @(posedge clock_200) begin
        if (reset) begin
            ovf1_q <= 1'b0;
        end else if (slice_enable) begin
            ovf1_q <= overflow_stage_1;
        end
    end

    // On overflow the wrapped sign is the inverse of the true sign.
    always_comb begin
        sat_active = ovf1_q | overflow_stage_2;
        wdata      = add_sub_result;
        if (sat_active) begin
            wdata = add_sub_result[DATA_W-1] ? FullPos : FullNeg;
        end
    end

    // Store has no reset; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clock_200) begin
        if (!reset) begin
            if (state_q == StClear) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (slice_enable) begin
                mem_q[state_write_adr] <= wdata;
            end
        end
    end

    always_ff @(posedge clock_200) begin
        if (reset) begin
            state_value_q <= '0;
            log_value_q   <= '0;
            sigma_delta_q <= '0;
            sat_event_q   <= 1'b0;
            sat_count_q   <= '0;
        end else begin
            sat_event_q <= run_en && sat_active;
            if (state_q == StClear) begin
                state_value_q <= '0;
            end else if (slice_enable) begin
                // Write-first bypass when reading the address being written.
                if (state_read_adr == state_write_adr) begin
                    state_value_q <= wdata;
                end else begin
                    state_value_q <= mem_q[state_read_adr];
                end
                if (log_trigger) begin
                    log_value_q <= wdata;
                end
                if (sigma_delta_out_trigger) begin
                    sigma_delta_q <= wdata;
                end
                if (sat_active && (sat_count_q != {SAT_CNT_W{1'b1}})) begin
                    sat_count_q <= sat_count_q + 1'b1;
                end
            end
        end
    end

    assign state_value     = state_value_q;
    assign log_value_out   = log_value_q;
    assign sigma_delta_out = sigma_delta_q;
    assign init_busy       = (state_q == StClear);
    assign sat_event       = sat_event_q;
    assign sat_count       = sat_count_q;

endmodule

// File: tb/tb_slice_state_writeback.sv
// Self-checking bench for slice_state_writeback: directed steps from the test
// plan plus a randomized phase, all checked against a cycle-level reference
// model of the store, captures and saturation counter.
module tb_slice_state_writeback;

    logic        clk;
    logic        reset;
    logic        en;
    logic [23:0] res;
    logic        ovf1;
    logic        ovf2;
    logic [3:0]  wadr;
    logic [3:0]  radr;
    logic        logt;
    logic        sdt;
    logic [23:0] sv;
    logic [23:0] logv;
    logic [23:0] sdv;
    logic        busy;
    logic        sev;
    logic [15:0] scnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [23:0] m_mem [16];
    logic [23:0] m_sv, m_log, m_sd;
    logic        m_evt;
    int          m_cnt;
    int          m_clear_left;
    logic        m_ovf1;

    slice_state_writeback dut (
        .clock_200               (clk),
        .reset                   (reset),
        .slice_enable            (en),
        .add_sub_result          (res),
        .overflow_stage_1        (ovf1),
        .overflow_stage_2        (ovf2),
        .state_write_adr         (wadr),
        .state_read_adr          (radr),
        .log_trigger             (logt),
        .sigma_delta_out_trigger (sdt),
        .state_value             (sv),
        .log_value_out           (logv),
        .sigma_delta_out         (sdv),
        .init_busy               (busy),
        .sat_event               (sev),
        .sat_count               (scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Saturated value derived from the true (unwrapped) sum, clamped to range.
    function automatic logic [23:0] model_wdata(logic [23:0] r, logic sat);
        int wrapped;
        int true_val;
        wrapped = $signed(r);
        if (!sat) return r;
        true_val = (wrapped < 0) ? wrapped + (1 << 24) : wrapped - (1 << 24);
        if (true_val > (1 << 23) - 1) true_val = (1 << 23) - 1;
        if (true_val < -(1 << 23)) true_val = -(1 << 23);
        return true_val[23:0];
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        logic        sat;
        logic [23:0] wd;
        if (reset) begin
            m_sv = 0; m_log = 0; m_sd = 0; m_evt = 0; m_cnt = 0;
            m_clear_left = 16;
            m_ovf1 = 0;
        end else if (m_clear_left > 0) begin
            m_mem[16 - m_clear_left] = 0;
            m_clear_left--;
            m_sv  = 0;
            m_evt = 0;
            if (en) m_ovf1 = ovf1;
        end else begin
            sat = m_ovf1 || ovf2;
            wd  = model_wdata(res, sat);
            m_evt = en && sat;
            if (en) begin
                m_sv = (radr == wadr) ? wd : m_mem[radr];
                if (logt) m_log = wd;
                if (sdt) m_sd = wd;
                if (sat && m_cnt < 65535) m_cnt++;
                m_mem[wadr] = wd;
                m_ovf1 = ovf1;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state_value", {8'd0, sv}, {8'd0, m_sv});
        chk("log_value_out", {8'd0, logv}, {8'd0, m_log});
        chk("sigma_delta_out", {8'd0, sdv}, {8'd0, m_sd});
        chk("init_busy", {31'd0, busy}, {31'd0, (m_clear_left > 0)});
        chk("sat_event", {31'd0, sev}, {31'd0, m_evt});
        chk("sat_count", {16'd0, scnt}, m_cnt);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(logic [23:0] r, logic o1, logic o2, logic [3:0] wa, logic [3:0] ra);
        res = r; ovf1 = o1; ovf2 = o2; wadr = wa; radr = ra;
    endtask

    initial begin
        reset = 1; en = 1; logt = 0; sdt = 0;
        drive(24'd0, 0, 0, 4'd0, 4'd0);

        // Reset held two cycles, then exactly 16 clear cycles.
        step();
        step();
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_sv", {8'd0, sv}, 32'd0);
        reset = 0;
        for (int i = 0; i < 16; i++) begin
            chk("clear_busy", {31'd0, busy}, 32'd1);
            // Writes and triggers during CLEAR must be ignored.
            drive(24'h123456, 0, 1, 4'(i), 4'(i));
            logt = 1; sdt = 1;
            step();
        end
        logt = 0; sdt = 0;
        chk("clear_done", {31'd0, busy}, 32'd0);
        chk("clear_no_evt", {31'd0, sev}, 32'd0);

        // Every address reads 0 after CLEAR (write 0 to adr 15 meanwhile).
        for (int i = 0; i < 16; i++) begin
            drive(24'd0, 0, 0, 4'd15, 4'(i));
            step();
            chk("cleared_read", {8'd0, sv}, 32'd0);
        end

        // Plain write-back then readback: 9485-7343-2394 = -252.
        drive(24'(9485 - 7343 - 2394), 0, 0, 4'd3, 4'd0);
        step();
        drive(24'd0, 0, 0, 4'd0, 4'd3);
        step();
        chk("readback", {8'd0, sv}, {8'd0, 24'hFFFF04});
        chk("readback_evt", {31'd0, sev}, 32'd0);

        // Positive saturation via stage-2 overflow.
        drive(24'h800005, 0, 1, 4'd5, 4'd0);
        step();
        chk("pos_sat_evt", {31'd0, sev}, 32'd1);
        chk("pos_sat_cnt", {16'd0, scnt}, 32'd1);
        drive(24'd0, 0, 0, 4'd0, 4'd5);
        step();
        chk("pos_sat_evt_end", {31'd0, sev}, 32'd0);
        chk("pos_sat_mem", {8'd0, sv}, {8'd0, 24'h7FFFFF});

        // Negative saturation via stage-1 overflow, one cycle early.
        drive(24'd0, 1, 0, 4'd0, 4'd0);
        step();
        chk("ovf1_early_evt", {31'd0, sev}, 32'd0);
        drive(24'h000010, 0, 0, 4'd5, 4'd0);
        step();
        chk("neg_sat_evt", {31'd0, sev}, 32'd1);
        chk("neg_sat_cnt", {16'd0, scnt}, 32'd2);
        drive(24'd0, 0, 0, 4'd0, 4'd5);
        step();
        chk("neg_sat_mem", {8'd0, sv}, {8'd0, 24'h800000});

        // Read-during-write bypass.
        drive(24'd111, 0, 0, 4'd7, 4'd0);
        step();
        drive(24'd4567, 0, 0, 4'd7, 4'd7);
        step();
        chk("bypass", {8'd0, sv}, 32'd4567);

        // Log trigger capture.
        drive(24'd1234, 0, 0, 4'd1, 4'd7);
        logt = 1;
        step();
        logt = 0;
        chk("log_capture", {8'd0, logv}, 32'd1234);

        // Stall: no capture, no write, state_value held.
        en = 0; sdt = 1;
        drive(24'd999, 0, 1, 4'd7, 4'd3);
        step();
        chk("stall_sd", {8'd0, sdv}, 32'd0);
        chk("stall_sv", {8'd0, sv}, 32'd4567);
        chk("stall_evt", {31'd0, sev}, 32'd0);
        en = 1; sdt = 0;
        drive(24'd0, 0, 0, 4'd0, 4'd7);
        step();
        chk("stall_no_write", {8'd0, sv}, 32'd4567);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            logt = ($urandom_range(0, 3) == 0);
            sdt  = ($urandom_range(0, 3) == 0);
            drive(24'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step();
        end
        en = 1; logt = 0; sdt = 0;

        // Drive sat_count to all-ones and check it sticks.
        drive(24'h400000, 0, 1, 4'd2, 4'd9);
        for (int i = 0; i < 70000 && m_cnt < 65535; i++) begin
            step();
        end
        chk("cnt_full", {16'd0, scnt}, 32'h0000FFFF);
        for (int i = 0; i < 4; i++) step();
        chk("cnt_sticky", {16'd0, scnt}, 32'h0000FFFF);

        // Reset mid-RUN: outputs clear, CLEAR reruns for 16 cycles.
        drive(24'd77, 0, 1, 4'd4, 4'd4);
        reset = 1;
        step();
        chk("rst2_busy", {31'd0, busy}, 32'd1);
        chk("rst2_cnt", {16'd0, scnt}, 32'd0);
        chk("rst2_sv", {8'd0, sv}, 32'd0);
        chk("rst2_log", {8'd0, logv}, 32'd0);
        reset = 0;
        drive(24'd0, 0, 0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) step();
        chk("rst2_clear_done", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive(24'd0, 0, 0, 4'd15, 4'(i));
            step();
            chk("rst2_cleared_read", {8'd0, sv}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slice_state_writeback.md
Name: slice_state_writeback

Overview:
- Downstream stage of the slice two-step add/sub chain: state ± coefficient A ± coefficient B.
- Takes the registered 24-bit final sum and both overflow flags, saturates the sum, and writes it into a 16-entry state store.
- Returns the next state_value to the chain from the same store.
- Captures log and sigma-delta output samples on trigger.
- Clears the store on reset, then counts saturation events.

Parameters:
- DATA_W, 24, state/result width; full_pos = {0,1..1}, full_neg = {1,0..0}
- ADR_W, 4, state address width; depth = 2**ADR_W
- SAT_CNT_W, 16, saturation event counter width

Ports:
- clock_200  in  1  slice clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- slice_enable  in  1  global clock enable for every state-changing action
- add_sub_result  in  DATA_W  registered signed sum from second add/sub
- overflow_stage_1  in  1  combinational overflow of first add/sub; one cycle earlier than its result
- overflow_stage_2  in  1  overflow of second add/sub; aligned with add_sub_result
- state_write_adr  in  ADR_W  write address, aligned with add_sub_result
- state_read_adr  in  ADR_W  read address for next state_value
- log_trigger  in  1  capture current write data into log_value_out
- sigma_delta_out_trigger  in  1  capture current write data into sigma_delta_out
- state_value  out  DATA_W  signed registered read data
- log_value_out  out  DATA_W  signed log sample
- sigma_delta_out  out  DATA_W  signed sigma-delta sample
- init_busy  out  1  high while the store is being cleared
- sat_event  out  1  one-cycle pulse when a write was saturated
- sat_count  out  SAT_CNT_W  saturating count of saturated writes

Behaviour:
- Clock and reset: one clock, clock_200. reset is synchronous, active-high. reset overrides slice_enable.
- Reset values:
  - All outputs are 0, except init_busy = 1.
  - The FSM goes to CLEAR with the clear pointer at 0.
  - The stage-1 overflow alignment register is 0.
- FSM, CLEAR state:
  - Writes 0 to mem[ptr] each cycle, regardless of slice_enable, and increments ptr.
  - After the write to address depth-1, goes to RUN. CLEAR lasts exactly depth = 16 cycles after reset falls.
  - init_busy = 1 for the whole state.
  - Incoming writes and triggers are ignored. state_value holds 0. sat_event is 0.
- FSM, RUN state:
  - init_busy = 0.
  - Asserting reset in RUN restarts CLEAR on the next edge. Any write in flight is discarded.
- Overflow alignment: ovf1_d <= overflow_stage_1 when slice_enable. ovf1_d then lines up with add_sub_result.
- Saturation, combinational on the write data:
  - If ovf1_d or overflow_stage_2 is set:
    - wdata = full_neg when add_sub_result[DATA_W-1] = 0.
    - wdata = full_pos when add_sub_result[DATA_W-1] = 1.
    - In both cases the true sign is taken as the inverse of the wrapped result.
  - Otherwise wdata = add_sub_result.
- Write, RUN and slice_enable: mem[state_write_adr] <= wdata.
- Saturation reporting, RUN and slice_enable with saturation active:
  - sat_event = 1 for the next cycle.
  - sat_count increments and sticks at all-ones.
- Read, RUN and slice_enable:
  - state_value <= mem[state_read_adr]. Latency is 1 cycle.
  - If state_read_adr == state_write_adr in the same cycle, state_value <= wdata (write-first bypass).
- Stall: when slice_enable = 0, the store, state_value, captures, ovf1_d and sat_count all hold. sat_event = 0.
- Captures, RUN and slice_enable:
  - log_trigger: log_value_out <= wdata.
  - sigma_delta_out_trigger: sigma_delta_out <= wdata.
  - Both triggers may be active in the same cycle; both registers then get the same wdata.
  - Captures hold between triggers.

Test Plan:
- Reset → CLEAR timing: reset high 2 cycles, then low → init_busy stays 1 for exactly 16 cycles, then 0. Reading addresses 0..15 in RUN returns 0.
- Plain write-back and readback:
  - Write adr 3 with result 9485-7343-2394 = -252, no overflow.
  - Read adr 3 on the next cycle → state_value = -252 one cycle later. sat_event = 0.
- Positive saturation:
  - add_sub_result = 0x800005 with overflow_stage_2 = 1, write adr 5.
  - → mem[5] = 0x7FFFFF, sat_event pulses 1 cycle, sat_count = 1.
  - Repeat with overflow_stage_1 = 1 asserted one cycle early and result 0x000010 → mem[5] = 0x800000, sat_count = 2.
- Read-during-write bypass: read and write adr 7 in the same cycle with result 4567 → state_value = 4567 next cycle, not the old value.
- Triggers and stall:
  - log_trigger with wdata 1234 → log_value_out = 1234.
  - slice_enable = 0 with sigma_delta_out_trigger = 1 and a new result → no capture, no write, state_value held.
- Reset mid-RUN and counter saturation:
  - Preload sat_count to 0xFFFF via saturated writes → it stays 0xFFFF.
  - Assert reset → next cycle all outputs 0, init_busy = 1, store cleared after 16 cycles.
